axi_lite_master: RTL and testbench

//  AXI-Lite initiator: turns single-beat core memory requests (IFU/LSU side) into
//  AXI-Lite read or write transactions toward a slave (e.g. the DRAM model).
//  One outstanding transaction at a time. Returns read data and error status to the core.

---
 rtl/axi_lite_pkg.sv | 32 +++
 rtl/axi_lite_master.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_master.sv | 370 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI-Lite types, widths and response helper
// Purpose: response codes, initiator state encoding and bus widths shared by
//          the initiator and any slave models built against it.
// Ports:   none (package).
package axi_lite_pkg;

    localparam int AXI_DATA_WIDTH = 32;
    localparam int AXI_ADDR_WIDTH = 32;
    localparam int AXI_STRB_WIDTH = 4;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } resp_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_DONE    = 3'd5
    } master_state_e;

    // SLVERR and DECERR both report an error to the core; OKAY/EXOKAY do not.
    function automatic logic resp_is_err(input logic [1:0] resp);
        return (resp == SLVERR) || (resp == DECERR);
    endfunction

endpackage

// File: rtl/axi_lite_master.sv
// rtl/axi_lite_master.sv - single-outstanding AXI-Lite initiator for core requests
// Purpose: accepts one core read/write request at a time and runs it as an
//          AXI-Lite transaction, returning read data and error status with a
//          one-cycle completion pulse.
// Ports:
//   clk_i, rst_i                     clock, asynchronous active-high reset
//   req_valid_i/req_ready_o          core request handshake
//   req_we_i, req_addr_i,
//   req_wdata_i, req_wstrb_i         request payload
//   resp_valid_o, resp_rdata_o,
//   resp_err_o                       completion pulse, read data, error flag
//   araddr_o/arvalid_o/arready_i     AR channel
//   rdata_i/rresp_i/rvalid_i/rready_o  R channel
//   awaddr_o/awvalid_o/awready_i     AW channel
//   wdata_o/wstrb_o/wvalid_o/wready_i  W channel
//   bresp_i/bvalid_i/bready_o        B channel
module axi_lite_master #(
    parameter int DATA_WIDTH = 32,  // must be 32: wstrb is fixed at 4 bits
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    input  logic [3:0]            req_wstrb_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] araddr_o,
    output logic                  arvalid_o,
    input  logic                  arready_i,
    input  logic [DATA_WIDTH-1:0] rdata_i,
    input  logic [1:0]            rresp_i,
    input  logic                  rvalid_i,
    output logic                  rready_o,
    output logic [ADDR_WIDTH-1:0] awaddr_o,
    output logic                  awvalid_o,
    input  logic                  awready_i,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [3:0]            wstrb_o,
    output logic                  wvalid_o,
    input  logic                  wready_i,
    input  logic [1:0]            bresp_i,
    input  logic                  bvalid_i,
    output logic                  bready_o
);
    import axi_lite_pkg::*;

    master_state_e         r_state;
    logic                  r_aw_done;
    logic                  r_w_done;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wstrb;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic                  r_resp_valid;
    logic                  r_req_ready;
    logic                  r_arvalid;
    logic                  r_rready;
    logic                  r_awvalid;
    logic                  r_wvalid;
    logic                  r_bready;

    logic                  w_aw_fire;
    logic                  w_w_fire;

    assign w_aw_fire = r_awvalid && awready_i;
    assign w_w_fire  = r_wvalid && wready_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= ST_IDLE;
            r_aw_done    <= 1'b0;
            r_w_done     <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_wstrb      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= 1'b0;
            r_req_ready  <= 1'b1;
            r_arvalid    <= 1'b0;
            r_rready     <= 1'b0;
            r_awvalid    <= 1'b0;
            r_wvalid     <= 1'b0;
            r_bready     <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid_i) begin
                        r_addr      <= req_addr_i;
                        r_wdata     <= req_wdata_i;
                        r_wstrb     <= req_wstrb_i;
                        r_req_ready <= 1'b0;
                        if (req_we_i) begin
                            r_awvalid <= 1'b1;
                            r_wvalid  <= 1'b1;
                            r_state   <= ST_WR_REQ;
                        end else begin
                            r_arvalid <= 1'b1;
                            r_state   <= ST_RD_ADDR;
                        end
                    end
                end
                ST_RD_ADDR: begin
                    if (arready_i) begin
                        r_arvalid <= 1'b0;
                        r_rready  <= 1'b1;
                        r_state   <= ST_RD_DATA;
                    end
                end
                ST_RD_DATA: begin
                    if (rvalid_i) begin
                        r_rready     <= 1'b0;
                        r_rdata      <= rdata_i;
                        r_err        <= resp_is_err(rresp_i);
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_WR_REQ: begin
                    // AW and W complete independently; the done flags remember
                    // which one has already handshaken so its valid stays low.
                    if (w_aw_fire) begin
                        r_awvalid <= 1'b0;
                        r_aw_done <= 1'b1;
                    end
                    if (w_w_fire) begin
                        r_wvalid <= 1'b0;
                        r_w_done <= 1'b1;
                    end
                    if ((r_aw_done || w_aw_fire) && (r_w_done || w_w_fire)) begin
                        r_aw_done <= 1'b0;
                        r_w_done  <= 1'b0;
                        r_bready  <= 1'b1;
                        r_state   <= ST_WR_RESP;
                    end
                end
                ST_WR_RESP: begin
                    if (bvalid_i) begin
                        r_bready     <= 1'b0;
                        r_err        <= resp_is_err(bresp_i);
                        r_resp_valid <= 1'b1;
                        r_state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Error flag is only meaningful alongside the pulse.
                    r_resp_valid <= 1'b0;
                    r_err        <= 1'b0;
                    r_req_ready  <= 1'b1;
                    r_state      <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign req_ready_o  = r_req_ready;
    assign resp_valid_o = r_resp_valid;
    assign resp_rdata_o = r_rdata;
    assign resp_err_o   = r_err;
    assign araddr_o     = r_addr;
    assign arvalid_o    = r_arvalid;
    assign rready_o     = r_rready;
    assign awaddr_o     = r_addr;
    assign awvalid_o    = r_awvalid;
    assign wdata_o      = r_wdata;
    assign wstrb_o      = r_wstrb;
    assign wvalid_o     = r_wvalid;
    assign bready_o     = r_bready;

endmodule

// File: tb/tb_axi_lite_master.sv
// tb/tb_axi_lite_master.sv - scoreboard bench for axi_lite_master
module tb_axi_lite_master;
    import axi_lite_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_valid_i = 1'b0, req_ready_o, req_we_i = 1'b0;
    logic [31:0] req_addr_i = '0, req_wdata_i = '0;
    logic [3:0]  req_wstrb_i = '0;
    logic        resp_valid_o, resp_err_o;
    logic [31:0] resp_rdata_o;
    logic [31:0] araddr_o, awaddr_o, wdata_o;
    logic        arvalid_o, arready_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [1:0]  rresp_i = '0, bresp_i = '0;
    logic        rvalid_i = 1'b0, rready_o;
    logic        awvalid_o, awready_i = 1'b0;
    logic [3:0]  wstrb_o;
    logic        wvalid_o, wready_i = 1'b0;
    logic        bvalid_i = 1'b0, bready_o;

    axi_lite_master #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wstrb_i(req_wstrb_i),
        .resp_valid_o(resp_valid_o), .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o),
        .araddr_o(araddr_o), .arvalid_o(arvalid_o), .arready_i(arready_i),
        .rdata_i(rdata_i), .rresp_i(rresp_i), .rvalid_i(rvalid_i), .rready_o(rready_o),
        .awaddr_o(awaddr_o), .awvalid_o(awvalid_o), .awready_i(awready_i),
        .wdata_o(wdata_o), .wstrb_o(wstrb_o), .wvalid_o(wvalid_o), .wready_i(wready_i),
        .bresp_i(bresp_i), .bvalid_i(bvalid_i), .bready_o(bready_o)
    );

    always #5 clk_i = ~clk_i;

    int n_chk = 0;
    int n_fail = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endfunction

    function automatic void chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event did not match expectation", name);
    endfunction

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ar_q[$];
    logic [31:0] aw_q[$];
    logic [31:0] wd_q[$];
    logic [3:0]  ws_q[$];
    logic [31:0] last_rd = '0;

    // Slave behaviour knobs
    int          cfg_ar_dly = 0, cfg_r_dly = 0, cfg_aw_dly = 0, cfg_w_dly = 0, cfg_b_dly = 0;
    logic [31:0] cfg_rdata = '0;
    logic [1:0]  cfg_rresp = '0, cfg_bresp = '0;

    // Handshake flags: set at negedge, meaning the transfer happens on the next posedge
    logic f_req = 0, f_ar = 0, f_r = 0, f_aw = 0, f_w = 0, f_b = 0;
    int   cyc = 0, fire_cyc = 0, ar_hs = 0, resp_cnt = 0;

    logic        p_arvalid = 0, p_arready = 0, p_awvalid = 0, p_awready = 0;
    logic        p_wvalid = 0, p_wready = 0, p_rready = 0, p_rvalid = 0;
    logic        p_bready = 0, p_bvalid = 0, p_resp_valid = 0;
    logic [31:0] p_araddr = '0, p_awaddr = '0, p_wdata = '0;
    logic [3:0]  p_wstrb = '0;

    always @(posedge clk_i) cyc++;

    // Monitor / scoreboard
    always @(negedge clk_i) begin
        if (rst_i) begin
            {f_req, f_ar, f_r, f_aw, f_w, f_b} = '0;
            {p_arvalid, p_arready, p_awvalid, p_awready, p_wvalid, p_wready} = '0;
            {p_rready, p_rvalid, p_bready, p_bvalid, p_resp_valid} = '0;
        end else begin
            if (p_arvalid && !p_arready) begin
                chk1("arvalid_hold", arvalid_o, 1'b1);
                chk("araddr_stable", araddr_o, p_araddr);
            end
            if (p_awvalid && !p_awready) begin
                chk1("awvalid_hold", awvalid_o, 1'b1);
                chk("awaddr_stable", awaddr_o, p_awaddr);
            end
            if (p_wvalid && !p_wready) begin
                chk1("wvalid_hold", wvalid_o, 1'b1);
                chk("wdata_stable", wdata_o, p_wdata);
                chk("wstrb_stable", 32'(wstrb_o), 32'(p_wstrb));
            end
            if (f_ar) chk1("arvalid_drop", arvalid_o, 1'b0);
            if (f_aw) chk1("awvalid_drop", awvalid_o, 1'b0);
            if (f_w)  chk1("wvalid_drop", wvalid_o, 1'b0);
            if (p_rready && !p_rvalid) chk1("rready_hold", rready_o, 1'b1);
            if (p_bready && !p_bvalid) chk1("bready_hold", bready_o, 1'b1);
            if (f_r || f_b) chk1("resp_after_fire", resp_valid_o, 1'b1);
            if (p_resp_valid) chk1("resp_one_cycle", resp_valid_o, 1'b0);
            if (req_ready_o)
                chk("req_ready_only_idle",
                    32'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, resp_valid_o}), 32'd0);

            if (arvalid_o && arready_i) begin
                ar_hs++;
                if (ar_q.size() == 0) fail_now("ar_unexpected");
                else chk("araddr", araddr_o, ar_q.pop_front());
            end
            if (awvalid_o && awready_i) begin
                if (aw_q.size() == 0) fail_now("aw_unexpected");
                else chk("awaddr", awaddr_o, aw_q.pop_front());
            end
            if (wvalid_o && wready_i) begin
                if (wd_q.size() == 0) fail_now("w_unexpected");
                else begin
                    chk("wdata", wdata_o, wd_q.pop_front());
                    chk("wstrb", 32'(wstrb_o), 32'(ws_q.pop_front()));
                end
            end
            if (resp_valid_o) begin
                resp_cnt++;
                if (exp_q.size() == 0) fail_now("resp_unexpected");
                else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("resp_rdata", resp_rdata_o, e.rdata);
                    chk1("resp_err", resp_err_o, e.err);
                    chk("latency", cyc - fire_cyc, e.lat);
                end
            end

            f_req = req_valid_i && req_ready_o;
            if (f_req) fire_cyc = cyc;
            f_ar = arvalid_o && arready_i;
            f_r  = rvalid_i && rready_o;
            f_aw = awvalid_o && awready_i;
            f_w  = wvalid_o && wready_i;
            f_b  = bvalid_i && bready_o;
            p_arvalid = arvalid_o; p_arready = arready_i; p_araddr = araddr_o;
            p_awvalid = awvalid_o; p_awready = awready_i; p_awaddr = awaddr_o;
            p_wvalid = wvalid_o; p_wready = wready_i; p_wdata = wdata_o; p_wstrb = wstrb_o;
            p_rready = rready_o; p_rvalid = rvalid_i;
            p_bready = bready_o; p_bvalid = bvalid_i;
            p_resp_valid = resp_valid_o;
        end
    end

    // Slave model: one process per channel, driving just after the active edge
    int ar_cnt = 0, aw_cnt = 0, w_cnt = 0, r_cnt = 0, b_cnt = 0;
    logic r_pend = 0, b_pend = 0, aw_seen = 0, w_seen = 0;

    initial forever begin
        @(posedge clk_i); #1;
        if (rst_i) begin arready_i = 0; ar_cnt = 0; end
        else if (f_ar) arready_i = 0;
        else if (arvalid_o && !arready_i) begin
            if (ar_cnt >= cfg_ar_dly) begin arready_i = 1; ar_cnt = 0; end
            else ar_cnt++;
        end
    end

    initial forever begin
        @(posedge clk_i); #1;
        if (rst_i) begin awready_i = 0; aw_cnt = 0; end
        else if (f_aw) awready_i = 0;
        else if (awvalid_o && !awready_i) begin
            if (aw_cnt >= cfg_aw_dly) begin awready_i = 1; aw_cnt = 0; end
            else aw_cnt++;
        end
    end

    initial forever begin
        @(posedge clk_i); #1;
        if (rst_i) begin wready_i = 0; w_cnt = 0; end
        else if (f_w) wready_i = 0;
        else if (wvalid_o && !wready_i) begin
            if (w_cnt >= cfg_w_dly) begin wready_i = 1; w_cnt = 0; end
            else w_cnt++;
        end
    end

    initial forever begin
        @(posedge clk_i); #1;
        if (rst_i) begin rvalid_i = 0; r_pend = 0; r_cnt = 0; end
        else begin
            if (f_r) rvalid_i = 0;
            if (f_ar) begin r_pend = 1; r_cnt = 0; end
            if (r_pend) begin
                if (r_cnt >= cfg_r_dly) begin
                    rvalid_i = 1; rdata_i = cfg_rdata; rresp_i = cfg_rresp; r_pend = 0;
                end else r_cnt++;
            end
        end
    end

    initial forever begin
        @(posedge clk_i); #1;
        if (rst_i) begin bvalid_i = 0; b_pend = 0; b_cnt = 0; aw_seen = 0; w_seen = 0; end
        else begin
            if (f_b) bvalid_i = 0;
            if (f_aw) aw_seen = 1;
            if (f_w) w_seen = 1;
            if (aw_seen && w_seen) begin b_pend = 1; b_cnt = 0; aw_seen = 0; w_seen = 0; end
            if (b_pend) begin
                if (b_cnt >= cfg_b_dly) begin bvalid_i = 1; bresp_i = cfg_bresp; b_pend = 0; end
                else b_cnt++;
            end
        end
    end

    task automatic wait_req_fire(output logic got);
        got = 0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(posedge clk_i); #1;
            if (f_req) got = 1;
        end
    endtask

    task automatic push_exp(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input logic [31:0] rd, input logic err,
                            input int lat);
        exp_t e;
        if (we) begin
            aw_q.push_back(addr); wd_q.push_back(wdata); ws_q.push_back(strb);
            e.rdata = last_rd;
        end else begin
            ar_q.push_back(addr);
            last_rd = rd;
            e.rdata = rd;
        end
        e.err = err;
        e.lat = lat;
        exp_q.push_back(e);
    endtask

    task automatic wait_resp(input int target, input string name);
        for (int i = 0; i < 200 && resp_cnt < target; i++) begin
            @(posedge clk_i); #1;
        end
        if (resp_cnt < target) fail_now(name);
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input logic [31:0] rd, input logic [1:0] rr,
                         input logic [1:0] br, input logic err, input int lat);
        logic got;
        int   start;
        start = resp_cnt;
        cfg_rdata = rd; cfg_rresp = rr; cfg_bresp = br;
        req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_wstrb_i = strb;
        req_valid_i = 1;
        wait_req_fire(got);
        req_valid_i = 0;
        if (!got) fail_now("req_accept_timeout");
        else begin
            push_exp(we, addr, wdata, strb, rd, err, lat);
            wait_resp(start + 1, "resp_timeout");
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic got;
        int   ar0, rs0;

        // Reset state
        repeat (2) @(negedge clk_i);
        chk1("rst_req_ready", req_ready_o, 1'b1);
        chk("rst_valids", 32'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o}), 32'd0);
        chk1("rst_resp_valid", resp_valid_o, 1'b0);
        chk1("rst_resp_err", resp_err_o, 1'b0);
        chk("rst_rdata", resp_rdata_o, 32'd0);
        chk("rst_addr", araddr_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 0;
        @(negedge clk_i);
        chk1("post_rst_req_ready", req_ready_o, 1'b1);
        @(posedge clk_i); #1;

        // Read, rvalid 10 cycles into the data phase
        cfg_ar_dly = 0; cfg_r_dly = 10;
        issue(0, 32'h8000_0000, 32'h0, 4'h0, 32'hDEAD_BEEF, OKAY, OKAY, 1'b0, 13);

        // Write, awready two cycles ahead of wready
        cfg_r_dly = 0; cfg_aw_dly = 0; cfg_w_dly = 2; cfg_b_dly = 0;
        issue(1, 32'h0000_1000, 32'h1234_5678, 4'h3, 32'h0, OKAY, OKAY, 1'b0, 5);

        // Write, AW and W together, bvalid 5 cycles late
        cfg_w_dly = 0; cfg_b_dly = 5;
        issue(1, 32'h0000_2004, 32'hA5A5_0F0F, 4'hF, 32'h0, OKAY, OKAY, 1'b0, 8);

        // Error responses; read data must survive the write
        cfg_b_dly = 0;
        issue(0, 32'h4000_0010, 32'h0, 4'h0, 32'h0BAD_F00D, DECERR, OKAY, 1'b1, 3);
        issue(1, 32'h4000_0020, 32'h5555_AAAA, 4'h9, 32'h0, OKAY, SLVERR, 1'b1, 3);

        // Three reads with req_valid held high throughout
        ar0 = ar_hs; rs0 = resp_cnt;
        cfg_rdata = 32'hCAFE_0001; cfg_rresp = EXOKAY;
        req_we_i = 0; req_addr_i = 32'h0000_0100; req_valid_i = 1;
        for (int i = 0; i < 3; i++) begin
            wait_req_fire(got);
            if (!got) fail_now("burst_accept_timeout");
            else push_exp(0, 32'h0000_0100 + 32'(i * 4), 32'h0, 4'h0, 32'hCAFE_0001, 1'b0, 3);
            req_addr_i = 32'h0000_0104 + 32'(i * 4);
            if (i == 2) req_valid_i = 0;
        end
        wait_resp(rs0 + 3, "burst_resp_timeout");
        repeat (3) @(posedge clk_i);
        #1;
        chk("burst_ar_handshakes", ar_hs - ar0, 3);
        chk("burst_resp_pulses", resp_cnt - rs0, 3);

        // Reset while waiting for read data
        cfg_r_dly = 20; cfg_rdata = 32'h1111_2222; cfg_rresp = OKAY;
        req_we_i = 0; req_addr_i = 32'h0000_0300; req_valid_i = 1;
        wait_req_fire(got);
        req_valid_i = 0;
        if (!got) fail_now("rst_case_accept_timeout");
        else ar_q.push_back(32'h0000_0300);
        got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk_i); #1;
            if (rready_o) got = 1;
        end
        chk1("rst_case_in_rd_data", got, 1'b1);
        #1;
        rst_i = 1;
        @(negedge clk_i);
        chk("mid_rst_valids", 32'({arvalid_o, awvalid_o, wvalid_o, rready_o, bready_o, resp_valid_o}), 32'd0);
        chk("mid_rst_rdata", resp_rdata_o, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 0;
        last_rd = '0;
        ar_q.delete(); exp_q.delete();
        @(negedge clk_i);
        chk1("rst_release_req_ready", req_ready_o, 1'b1);
        @(posedge clk_i); #1;
        cfg_r_dly = 0;
        issue(0, 32'h0000_0400, 32'h0, 4'h0, 32'h7777_8888, OKAY, OKAY, 1'b0, 3);

        repeat (3) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
